audio_frame_sequencer: RTL and testbench
========================================

AUDIO_FRAME_SEQUENCER -- requirements
Module: audio_frame_sequencer

Interface
REQ-001 SHALL have parameter INPUTS_TO_FILL, default 64, meaning number of input blocks per frame.
REQ-002 SHALL have parameter SAMPLES, default 2048, meaning samples per frame (sizes the coefficient index).
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16384, meaning maximum RUN duration before error.
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 cmd_valid  input  1  CPU command present.
REQ-007 cmd_ready  output  1  command accepted this cycle when high with cmd_valid.
REQ-008 cmd_op  input  3  0 NOP, 1 LDE, 2 STE, 3 SPM, 4 SFC, 5 SYN, 6 CLR, 7 reserved.
REQ-009 cmd_index  input  $clog2(SAMPLES)  block index (LDE/STE) or coefficient index (SFC).
REQ-010 cmd_err  output  1  one-cycle pulse: accepted command was rejected as illegal.
REQ-011 data_wr_en, pitch_shift_wr_en, freq_coeff_wr_en, start  output  1 each  registered strobes to the processor.
REQ-012 input_index, output_index  output  $clog2(INPUTS_TO_FILL)  block selects to the processor.
REQ-013 freq_coeff_index  output  $clog2(SAMPLES)  coefficient select to the processor.
REQ-014 proc_done  input  1  processor completion pulse.
REQ-015 busy, frame_done, timeout  output  1 each  RUN indicator, done pulse, sticky error flag.
REQ-016 frame_count  output  16  completed frames, wraps at 65535->0.

Function
REQ-017 States SHALL be IDLE, LOADING, RUN, DONE, ERROR.
REQ-018 Handshake: command accepted iff cmd_valid && cmd_ready; processor strobes/indices assert exactly one cycle after acceptance, one cycle wide.
REQ-019 cmd_ready SHALL be 1 in IDLE, LOADING, DONE, ERROR; in RUN it SHALL be 1 only for NOP, 0 otherwise.
REQ-020 LDE with cmd_index < INPUTS_TO_FILL: data_wr_en pulse, input_index=cmd_index, set bit in 64-bit load bitmap; IDLE/DONE -> LOADING; rewrites of a set bit are legal.
REQ-021 LDE or STE with cmd_index >= INPUTS_TO_FILL: cmd_err pulse, no strobe, no state change.
REQ-022 SPM/SFC: pitch_shift_wr_en or freq_coeff_wr_en pulse (freq_coeff_index=cmd_index); no state change.
REQ-023 SYN with bitmap all-ones: start pulse, bitmap cleared, watchdog cleared, -> RUN; otherwise cmd_err, no start.
REQ-024 RUN: busy=1; proc_done -> DONE, frame_done pulse same cycle as transition, frame_count+1.
REQ-025 RUN: watchdog increments each cycle; at TIMEOUT_CYCLES-1 without proc_done -> ERROR, timeout set.
REQ-026 proc_done and watchdog terminal in same cycle: proc_done wins (DONE, timeout not set).
REQ-027 proc_done outside RUN SHALL be ignored.
REQ-028 STE: legal only in DONE (elsewhere cmd_err); output_index=cmd_index held until next STE; STE of index INPUTS_TO_FILL-1 -> IDLE.
REQ-029 ERROR: only CLR and NOP legal; CLR -> IDLE, clears timeout and bitmap; other ops cmd_err.
REQ-030 CLR in any state other than RUN -> IDLE, clears bitmap; frame_count unaffected.
REQ-031 Reserved op: cmd_err pulse, no other effect.

Reset
REQ-032 On rst_n low: state IDLE, all strobes/cmd_err/frame_done 0, indices 0, bitmap 0, watchdog 0, frame_count 0, timeout 0, busy 0.
REQ-033 Reset during RUN SHALL abandon the frame without start or frame_done pulse.

Structure
REQ-034 Opcode enum, state enum and INPUTS_TO_FILL/SAMPLES constants SHALL live in shared package audio_pkg.
REQ-035 Watchdog counter SHALL be sub-module frame_watchdog (clear, enable, terminal-count output).

Verification
REQ-036 LDE indices 0..63, SYN -> start pulse cycle after SYN accept, busy=1; proc_done 200 cycles later -> frame_done, frame_count=1.
REQ-037 LDE indices 0..62, SYN -> cmd_err, no start, state LOADING; LDE 63 then SYN -> start.
REQ-038 RUN with no proc_done, TIMEOUT_CYCLES=16 -> ERROR after 16 cycles, timeout=1; LDE -> cmd_err; CLR -> IDLE, timeout=0.
REQ-039 During RUN issue SFC index 5 -> cmd_ready=0, no freq_coeff_wr_en; NOP accepted.
REQ-040 DONE: STE 0..63 -> output_index follows, IDLE after 63; STE 64 -> cmd_err.
REQ-041 proc_done coincident with watchdog terminal -> DONE, timeout=0; rst_n low mid-RUN -> all outputs zero.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types for the audio frame sequencer.
// Opcodes, FSM states and default frame geometry.
package audio_pkg;

  localparam int AUDIO_INPUTS_TO_FILL = 64;
  localparam int AUDIO_SAMPLES        = 2048;

  typedef enum logic [2:0] {
    OP_NOP = 3'd0,
    OP_LDE = 3'd1,
    OP_STE = 3'd2,
    OP_SPM = 3'd3,
    OP_SFC = 3'd4,
    OP_SYN = 3'd5,
    OP_CLR = 3'd6,
    OP_RSV = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOADING = 3'd1,
    ST_RUN     = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERROR   = 3'd4
  } state_e;

endpackage

// File: rtl/frame_watchdog.sv
// RUN-phase watchdog: counts enabled cycles from a clear.
// Ports: clk, rst_n, clear, enable in; terminal out at TIMEOUT_CYCLES-1.
module frame_watchdog #(
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] count_q, count_d;

  assign terminal = (count_q == CW'(TIMEOUT_CYCLES - 1));

  // Holds at terminal so a stale count never wraps back below it.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !terminal) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/audio_frame_sequencer.sv
// CPU command sequencer driving an audio frame processor.
// Ports: cmd_* handshake, processor strobes/indices, proc_done, status outputs.
module audio_frame_sequencer
  import audio_pkg::*;
#(
  parameter int INPUTS_TO_FILL = AUDIO_INPUTS_TO_FILL,
  parameter int SAMPLES        = AUDIO_SAMPLES,
  parameter int TIMEOUT_CYCLES = 16384
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic [2:0]                        cmd_op,
  input  logic [$clog2(SAMPLES)-1:0]        cmd_index,
  output logic                              cmd_err,
  output logic                              data_wr_en,
  output logic                              pitch_shift_wr_en,
  output logic                              freq_coeff_wr_en,
  output logic                              start,
  output logic [$clog2(INPUTS_TO_FILL)-1:0] input_index,
  output logic [$clog2(INPUTS_TO_FILL)-1:0] output_index,
  output logic [$clog2(SAMPLES)-1:0]        freq_coeff_index,
  input  logic                              proc_done,
  output logic                              busy,
  output logic                              frame_done,
  output logic                              timeout,
  output logic [15:0]                       frame_count
);

  localparam int IW = $clog2(INPUTS_TO_FILL);
  localparam int SW = $clog2(SAMPLES);

  state_e                    state_q, state_d;
  logic [INPUTS_TO_FILL-1:0] map_q, map_d;
  logic                      err_q, err_d;
  logic                      dwr_q, dwr_d;
  logic                      pwr_q, pwr_d;
  logic                      fwr_q, fwr_d;
  logic                      start_q, start_d;
  logic                      fdone_q, fdone_d;
  logic                      tout_q, tout_d;
  logic [IW-1:0]             in_idx_q, in_idx_d;
  logic [IW-1:0]             out_idx_q, out_idx_d;
  logic [SW-1:0]             fc_idx_q, fc_idx_d;
  logic [15:0]               fcnt_q, fcnt_d;

  logic accept, in_range, is_last, in_err;
  logic wd_clear, wd_terminal;
  op_e  op;

  assign op        = op_e'(cmd_op);
  assign cmd_ready = (state_q != ST_RUN) || (op == OP_NOP);
  assign accept    = cmd_valid && cmd_ready;
  assign in_range  = 32'(cmd_index) < 32'(INPUTS_TO_FILL);
  assign is_last   = 32'(cmd_index) == 32'(INPUTS_TO_FILL - 1);
  assign in_err    = (state_q == ST_ERROR);

  frame_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wd (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .enable  (state_q == ST_RUN),
    .terminal(wd_terminal)
  );

  always_comb begin
    state_d   = state_q;
    map_d     = map_q;
    err_d     = 1'b0;
    dwr_d     = 1'b0;
    pwr_d     = 1'b0;
    fwr_d     = 1'b0;
    start_d   = 1'b0;
    fdone_d   = 1'b0;
    tout_d    = tout_q;
    in_idx_d  = in_idx_q;
    out_idx_d = out_idx_q;
    fc_idx_d  = fc_idx_q;
    fcnt_d    = fcnt_q;
    wd_clear  = 1'b0;

    // Completion beats a coincident watchdog expiry.
    if (state_q == ST_RUN) begin
      if (proc_done) begin
        state_d = ST_DONE;
        fdone_d = 1'b1;
        fcnt_d  = fcnt_q + 16'd1;
      end else if (wd_terminal) begin
        state_d = ST_ERROR;
        tout_d  = 1'b1;
      end
    end

    // Only NOP can be accepted in RUN, so no overlap with the above.
    if (accept) begin
      unique case (op)
        OP_NOP: ;
        OP_LDE: begin
          if (in_err || !in_range) begin
            err_d = 1'b1;
          end else begin
            dwr_d    = 1'b1;
            in_idx_d = cmd_index[IW-1:0];
            map_d[cmd_index[IW-1:0]] = 1'b1;
            state_d  = ST_LOADING;
          end
        end
        OP_STE: begin
          if (state_q != ST_DONE || !in_range) begin
            err_d = 1'b1;
          end else begin
            out_idx_d = cmd_index[IW-1:0];
            if (is_last) state_d = ST_IDLE;
          end
        end
        OP_SPM: begin
          if (in_err) err_d = 1'b1;
          else        pwr_d = 1'b1;
        end
        OP_SFC: begin
          if (in_err) begin
            err_d = 1'b1;
          end else begin
            fwr_d    = 1'b1;
            fc_idx_d = cmd_index;
          end
        end
        OP_SYN: begin
          if (in_err || !(&map_q)) begin
            err_d = 1'b1;
          end else begin
            start_d  = 1'b1;
            map_d    = '0;
            wd_clear = 1'b1;
            state_d  = ST_RUN;
          end
        end
        OP_CLR: begin
          state_d = ST_IDLE;
          map_d   = '0;
          tout_d  = 1'b0;
        end
        OP_RSV: err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      map_q     <= '0;
      err_q     <= 1'b0;
      dwr_q     <= 1'b0;
      pwr_q     <= 1'b0;
      fwr_q     <= 1'b0;
      start_q   <= 1'b0;
      fdone_q   <= 1'b0;
      tout_q    <= 1'b0;
      in_idx_q  <= '0;
      out_idx_q <= '0;
      fc_idx_q  <= '0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      map_q     <= map_d;
      err_q     <= err_d;
      dwr_q     <= dwr_d;
      pwr_q     <= pwr_d;
      fwr_q     <= fwr_d;
      start_q   <= start_d;
      fdone_q   <= fdone_d;
      tout_q    <= tout_d;
      in_idx_q  <= in_idx_d;
      out_idx_q <= out_idx_d;
      fc_idx_q  <= fc_idx_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign cmd_err           = err_q;
  assign data_wr_en        = dwr_q;
  assign pitch_shift_wr_en = pwr_q;
  assign freq_coeff_wr_en  = fwr_q;
  assign start             = start_q;
  assign frame_done        = fdone_q;
  assign timeout           = tout_q;
  assign busy              = (state_q == ST_RUN);
  assign input_index       = in_idx_q;
  assign output_index      = out_idx_q;
  assign freq_coeff_index  = fc_idx_q;
  assign frame_count       = fcnt_q;

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Self-checking bench for audio_frame_sequencer.
// Directed and random commands against a behavioural frame model.
module tb_audio_frame_sequencer;
  import audio_pkg::*;

  localparam int N  = 64;
  localparam int S  = 2048;
  localparam int T  = 16;
  localparam int IW = 6;
  localparam int SW = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd_op = 3'd0;
  logic [SW-1:0] cmd_index = '0;
  logic          proc_done = 1'b0;
  logic          cmd_ready, cmd_err;
  logic          data_wr_en, pitch_shift_wr_en;
  logic          freq_coeff_wr_en, start;
  logic [IW-1:0] input_index, output_index;
  logic [SW-1:0] freq_coeff_index;
  logic          busy, frame_done, timeout;
  logic [15:0]   frame_count;

  audio_frame_sequencer #(
    .INPUTS_TO_FILL(N),
    .SAMPLES       (S),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_index        (cmd_index),
    .cmd_err          (cmd_err),
    .data_wr_en       (data_wr_en),
    .pitch_shift_wr_en(pitch_shift_wr_en),
    .freq_coeff_wr_en (freq_coeff_wr_en),
    .start            (start),
    .input_index      (input_index),
    .output_index     (output_index),
    .freq_coeff_index (freq_coeff_index),
    .proc_done        (proc_done),
    .busy             (busy),
    .frame_done       (frame_done),
    .timeout          (timeout),
    .frame_count      (frame_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: which blocks are loaded, and what the frame is doing.
  bit loaded[N];
  bit running, in_done, in_err, to_flag;
  int run_cycles, frames;
  int e_in, e_out, e_fc;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    foreach (loaded[i]) loaded[i] = 1'b0;
    running = 0; in_done = 0; in_err = 0; to_flag = 0;
    run_cycles = 0; frames = 0;
    e_in = 0; e_out = 0; e_fc = 0;
  endtask

  task automatic check_outs(input bit dwr, input bit pwr, input bit fwr,
                            input bit st, input bit err, input bit fd);
    chk("data_wr_en", data_wr_en, dwr);
    chk("pitch_wr_en", pitch_shift_wr_en, pwr);
    chk("freq_wr_en", freq_coeff_wr_en, fwr);
    chk("start", start, st);
    chk("cmd_err", cmd_err, err);
    chk("frame_done", frame_done, fd);
    chk("busy", busy, running);
    chk("timeout", timeout, to_flag);
    chk("frame_count", frame_count, frames);
    chk("input_index", input_index, e_in);
    chk("output_index", output_index, e_out);
    chk("fc_index", freq_coeff_index, e_fc);
  endtask

  task automatic step(input bit v, input logic [2:0] op,
                      input int idx, input bit pd);
    bit rdy, acc, inr, full;
    bit dwr, pwr, fwr, st, err, fd;
    dwr = 0; pwr = 0; fwr = 0; st = 0; err = 0; fd = 0;
    @(negedge clk);
    cmd_valid = v;
    cmd_op    = op;
    cmd_index = idx[SW-1:0];
    proc_done = pd;
    #1;
    rdy = !running || (op == OP_NOP);
    chk("cmd_ready", cmd_ready, rdy);
    acc = v && rdy;
    inr = idx < N;
    full = 1;
    foreach (loaded[i]) if (!loaded[i]) full = 0;
    if (running) begin
      if (pd) begin
        running = 0; in_done = 1; fd = 1;
        frames = (frames + 1) % 65536;
      end else if (run_cycles == T - 1) begin
        running = 0; in_err = 1; to_flag = 1;
      end else begin
        run_cycles++;
      end
    end
    if (acc) begin
      case (op)
        OP_LDE: begin
          if (in_err || !inr) err = 1;
          else begin
            dwr = 1; e_in = idx; loaded[idx] = 1; in_done = 0;
          end
        end
        OP_STE: begin
          if (!in_done || !inr) err = 1;
          else begin
            e_out = idx;
            if (idx == N - 1) in_done = 0;
          end
        end
        OP_SPM: if (in_err) err = 1; else pwr = 1;
        OP_SFC: begin
          if (in_err) err = 1;
          else begin fwr = 1; e_fc = idx; end
        end
        OP_SYN: begin
          if (in_err || !full) err = 1;
          else begin
            st = 1; running = 1; run_cycles = 0; in_done = 0;
            foreach (loaded[i]) loaded[i] = 0;
          end
        end
        OP_CLR: begin
          in_done = 0; in_err = 0; to_flag = 0;
          foreach (loaded[i]) loaded[i] = 0;
        end
        OP_RSV: err = 1;
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    check_outs(dwr, pwr, fwr, st, err, fd);
  endtask

  task automatic load_all(input int upto);
    int ord[N];
    int j, t;
    for (int i = 0; i < upto; i++) ord[i] = i;
    for (int i = upto - 1; i > 0; i--) begin
      j = $urandom_range(i, 0);
      t = ord[i]; ord[i] = ord[j]; ord[j] = t;
    end
    for (int i = 0; i < upto; i++) step(1, OP_LDE, ord[i], 0);
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) step(1, OP_NOP, 0, 0);
  endtask

  initial begin
    bit v, pd;
    int idx;
    logic [2:0] op;

    // Reset state
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", cmd_ready, 1'b1);
    check_outs(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full load, start, completion; RUN blocks SFC but takes NOP
    load_all(N);
    step(1, OP_SYN, 0, 0);
    step(1, OP_SFC, 5, 0);
    step(1, OP_NOP, 0, 0);
    nops(6);
    step(1, OP_NOP, 0, 1);

    // DONE: out-of-range STE, then walk all outputs back to IDLE
    step(1, OP_STE, N, 0);
    for (int i = 0; i < N; i++) step(1, OP_STE, i, 0);
    step(1, OP_STE, 3, 0);

    // Missing block blocks SYN; adding it allows start
    load_all(N - 1);
    step(1, OP_SYN, 0, 0);
    step(1, OP_LDE, N - 1, 0);
    step(1, OP_SYN, 0, 0);

    // Timeout path, ERROR rejects, CLR recovers
    nops(T);
    step(1, OP_LDE, 4, 0);
    step(1, OP_SPM, 0, 0);
    step(1, OP_SYN, 0, 0);
    step(1, OP_RSV, 0, 0);
    step(1, OP_CLR, 0, 0);

    // proc_done on the watchdog terminal cycle
    load_all(N);
    step(1, OP_SYN, 0, 0);
    for (int i = 0; i < T - 1; i++) step(1, OP_NOP, 0, 0);
    step(1, OP_NOP, 0, 1);

    // Stray proc_done, misc legal ops, reserved, CLR keeps count
    step(1, OP_NOP, 0, 1);
    step(1, OP_SPM, 0, 0);
    step(1, OP_SFC, S - 1, 0);
    step(1, OP_LDE, 70, 0);
    step(1, OP_RSV, 0, 1);
    step(1, OP_CLR, 0, 0);

    // Random mix
    for (int k = 0; k < 400; k++) begin
      if (k % 80 == 0) begin
        load_all(N);
        step(1, OP_SYN, 0, 0);
      end
      v  = ($urandom_range(3, 0) != 0);
      op = 3'($urandom_range(7, 0));
      if ($urandom_range(9, 0) < 8) idx = $urandom_range(N - 1, 0);
      else idx = $urandom_range(S - 1, 0);
      pd = ($urandom_range(7, 0) == 0);
      step(v, op, idx, pd);
    end

    // Reset mid-RUN abandons the frame
    step(1, OP_CLR, 0, 0);
    load_all(N);
    step(1, OP_SYN, 0, 0);
    nops(3);
    @(negedge clk);
    cmd_valid = 1'b0;
    proc_done = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("midrst_ready", cmd_ready, 1'b1);
    check_outs(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    proc_done = 1'b0;
    rst_n = 1'b1;
    step(1, OP_NOP, 0, 0);
    step(1, OP_SYN, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
